// File: rtl/config_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : config_cmd_initiator
// Description : Host-side initiator for the chip configuration protocol.
//               Accepts one write/read command at a time, builds the
//               WIDTH-1 bit packet for the tx UART, then for reads collects
//               matching replies from the rx UART.
// Ports       : clk, reset_n (async, active low)
//               cmd_valid/cmd_ready/cmd_write/cmd_chip_id/cmd_addr/cmd_wdata
//                 - command handshake and fields
//               tx_data/ld_tx_data/tx_busy - tx UART side
//               rx_data/rx_data_flag       - rx UART side
//               rsp_valid/rsp_chip_id/rsp_data - per-reply pulse and payload
//               cmd_done/rsp_timeout       - completion pulse and qualifier
//               busy                       - high outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module config_cmd_initiator #(
  parameter int         WIDTH          = 64,
  parameter logic [7:0] GLOBAL_ID      = 8'd255,
  parameter int         TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_chip_id,
  input  logic [7:0]       cmd_addr,
  input  logic [7:0]       cmd_wdata,
  output logic [WIDTH-2:0] tx_data,
  output logic             ld_tx_data,
  input  logic             tx_busy,
  input  logic [WIDTH-2:0] rx_data,
  input  logic             rx_data_flag,
  output logic             rsp_valid,
  output logic [7:0]       rsp_chip_id,
  output logic [7:0]       rsp_data,
  output logic             cmd_done,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int PW  = WIDTH - 1;
  // The counter never needs to exceed TIMEOUT_CYCLES-1.
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_TX_START = 3'd2,
    S_TX_DRAIN = 3'd3,
    S_REPLY    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;

  logic             r_cmd_write;
  logic             r_cmd_global;
  logic [7:0]       r_cmd_chip_id;
  logic [7:0]       r_cmd_addr;
  logic [TCW-1:0]   r_tcnt;
  logic [7:0]       r_rsp_count;
  logic             r_flag_d;

  logic             r_cmd_ready;
  logic [PW-1:0]    r_tx_data;
  logic             r_ld_tx_data;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_chip_id;
  logic [7:0]       r_rsp_data;
  logic             r_cmd_done;
  logic             r_rsp_timeout;
  logic             r_busy;

  logic [PW-1:0]    w_packet;
  logic             w_new_word;
  logic             w_id_ok;
  logic             w_match;
  logic             w_tmo;
  logic             w_tcnt_on;
  logic             w_latch;
  logic [PW-1:0]    w_tx_data;
  logic             w_ld_tx_data;
  logic             w_rsp_valid;
  logic [7:0]       w_rsp_chip_id;
  logic [7:0]       w_rsp_data;
  logic             w_cmd_done;
  logic             w_rsp_timeout;
  logic [7:0]       w_rsp_count;
  logic [7:0]       w_rsp_count_inc;
  logic             w_unused_rx;

  // Reserved reply bits carry nothing the initiator uses.
  assign w_unused_rx = ^rx_data[PW-2:26];

  // Command packet built straight from the request fields on accept.
  always_comb begin
    w_packet        = '0;
    w_packet[1:0]   = cmd_write ? 2'b10 : 2'b11;
    w_packet[9:2]   = cmd_chip_id;
    w_packet[17:10] = cmd_addr;
    w_packet[25:18] = cmd_write ? cmd_wdata : 8'd0;
  end

  // A level flag held high must count as a single word.
  assign w_new_word = rx_data_flag & ~r_flag_d;
  assign w_id_ok    = r_cmd_global | (rx_data[9:2] == r_cmd_chip_id);
  assign w_match    = w_new_word & rx_data[PW-1] & (rx_data[1:0] == 2'b11) &
                      (rx_data[17:10] == r_cmd_addr) & w_id_ok;

  assign w_tmo     = (r_tcnt == TC_LAST);
  assign w_tcnt_on = (r_state == S_SEND) || (r_state == S_TX_START) ||
                     (r_state == S_TX_DRAIN) || (r_state == S_REPLY);
  assign w_rsp_count_inc = (r_rsp_count == 8'hFF) ? r_rsp_count : r_rsp_count + 8'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_latch       = 1'b0;
    w_tx_data     = r_tx_data;
    w_ld_tx_data  = 1'b0;
    w_rsp_valid   = 1'b0;
    w_rsp_chip_id = r_rsp_chip_id;
    w_rsp_data    = r_rsp_data;
    w_cmd_done    = 1'b0;
    w_rsp_timeout = 1'b0;
    w_rsp_count   = r_rsp_count;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_latch     = 1'b1;
          w_tx_data   = w_packet;
          w_rsp_count = 8'd0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          w_ld_tx_data = 1'b1;
          w_state_nxt  = S_TX_START;
        end else if (w_tmo) begin
          w_cmd_done    = 1'b1;
          w_rsp_timeout = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_TX_START: begin
        if (tx_busy) begin
          w_state_nxt = S_TX_DRAIN;
        end else if (w_tmo) begin
          w_cmd_done    = 1'b1;
          w_rsp_timeout = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_TX_DRAIN: begin
        if (!tx_busy) begin
          w_rsp_count = 8'd0;
          w_state_nxt = r_cmd_write ? S_DONE : S_REPLY;
        end else if (w_tmo) begin
          w_cmd_done    = 1'b1;
          w_rsp_timeout = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_REPLY: begin
        // A match coinciding with the timeout is still taken.
        if (w_match) begin
          w_rsp_valid   = 1'b1;
          w_rsp_chip_id = rx_data[9:2];
          w_rsp_data    = rx_data[25:18];
          if (!r_cmd_global) begin
            w_cmd_done  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_rsp_count = w_rsp_count_inc;
            if (w_tmo) begin
              w_cmd_done  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end else if (w_tmo) begin
          // For a broadcast read that collected replies, the timeout is
          // simply the end of the collection window.
          w_cmd_done    = 1'b1;
          w_rsp_timeout = ~(r_cmd_global && (r_rsp_count != 8'd0));
          w_state_nxt   = S_IDLE;
        end
      end
      S_DONE: begin
        w_cmd_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_write   <= 1'b0;
      r_cmd_global  <= 1'b0;
      r_cmd_chip_id <= 8'd0;
      r_cmd_addr    <= 8'd0;
      r_tcnt        <= '0;
      r_rsp_count   <= 8'd0;
      r_flag_d      <= 1'b0;
      r_cmd_ready   <= 1'b1;
      r_tx_data     <= '0;
      r_ld_tx_data  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_chip_id <= 8'd0;
      r_rsp_data    <= 8'd0;
      r_cmd_done    <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_latch) begin
        r_cmd_write   <= cmd_write;
        r_cmd_global  <= (cmd_chip_id == GLOBAL_ID);
        r_cmd_chip_id <= cmd_chip_id;
        r_cmd_addr    <= cmd_addr;
      end
      if (w_state_nxt != r_state) begin
        r_tcnt <= '0;
      end else if (w_tcnt_on) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      r_rsp_count   <= w_rsp_count;
      r_flag_d      <= rx_data_flag;
      r_cmd_ready   <= (w_state_nxt == S_IDLE);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_tx_data     <= w_tx_data;
      r_ld_tx_data  <= w_ld_tx_data;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_chip_id <= w_rsp_chip_id;
      r_rsp_data    <= w_rsp_data;
      r_cmd_done    <= w_cmd_done;
      r_rsp_timeout <= w_rsp_timeout;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign tx_data     = r_tx_data;
  assign ld_tx_data  = r_ld_tx_data;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_chip_id = r_rsp_chip_id;
  assign rsp_data    = r_rsp_data;
  assign cmd_done    = r_cmd_done;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_config_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_cmd_initiator
// Description : Self-checking bench for config_cmd_initiator. Directed cases
//               plus randomized commands and reply streams, compared against
//               a packet/match model derived from the protocol rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_cmd_initiator;

  localparam int         W   = 64;
  localparam int         PW  = W - 1;
  localparam logic [7:0] GID = 8'hFF;
  localparam int         T   = 48;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [7:0]    cmd_chip_id = 8'd0;
  logic [7:0]    cmd_addr = 8'd0;
  logic [7:0]    cmd_wdata = 8'd0;
  logic          tx_busy = 1'b0;
  logic [PW-1:0] rx_data = '0;
  logic          rx_data_flag = 1'b0;
  logic          cmd_ready, ld_tx_data, rsp_valid, cmd_done, rsp_timeout, busy;
  logic [PW-1:0] tx_data;
  logic [7:0]    rsp_chip_id, rsp_data;

  config_cmd_initiator #(
    .WIDTH(W), .GLOBAL_ID(GID), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_chip_id(cmd_chip_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .tx_data(tx_data), .ld_tx_data(ld_tx_data), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_data_flag(rx_data_flag),
    .rsp_valid(rsp_valid), .rsp_chip_id(rsp_chip_id), .rsp_data(rsp_data),
    .cmd_done(cmd_done), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int            mon_ld = 0, mon_rsp = 0, mon_done = 0, done_cyc = 0;
  logic          mon_tmo = 1'b0;
  logic [7:0]    mon_chip = 8'd0, mon_data = 8'd0;
  logic [PW-1:0] mon_tx = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (ld_tx_data) begin mon_ld++; mon_tx = tx_data; end
      if (rsp_valid) begin mon_rsp++; mon_chip = rsp_chip_id; mon_data = rsp_data; end
      if (cmd_done) begin mon_done++; mon_tmo = rsp_timeout; done_cyc = cyc; end
    end
  end

  logic [PW-1:0] wq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear;
    mon_ld = 0; mon_rsp = 0; mon_done = 0; mon_tmo = 1'b0;
  endtask

  // Reference model: packet value as a sum of shifted fields.
  function automatic logic [PW-1:0] model_packet(input bit wr, input logic [7:0] chip,
                                                 input logic [7:0] addr, input logic [7:0] data);
    logic [63:0] v;
    v = (wr ? 64'd2 : 64'd3) + (64'(chip) << 2) + (64'(addr) << 10) +
        (wr ? (64'(data) << 18) : 64'd0);
    return v[PW-1:0];
  endfunction

  function automatic bit model_match(input logic [PW-1:0] w, input logic [7:0] chip,
                                     input logic [7:0] addr);
    return w[PW-1] && (w[1:0] == 2'b11) && (w[17:10] == addr) &&
           ((chip == GID) || (w[9:2] == chip));
  endfunction

  function automatic logic [PW-1:0] make_word(input logic [7:0] chip, input logic [7:0] addr,
                                              input logic [7:0] data);
    logic [PW-1:0] w;
    logic [63:0]   r;
    r = {$urandom(), $urandom()};
    w = r[PW-1:0];
    w[PW-1]   = 1'b1;
    w[25:18]  = data;
    w[17:10]  = addr;
    w[9:2]    = chip;
    w[1:0]    = 2'b11;
    return w;
  endfunction

  // One complete command, with a tx UART model and the queued reply words.
  task automatic do_cmd(input bit wr, input logic [7:0] chip, input logic [7:0] addr,
                        input logic [7:0] wdata, input int hold, input bit late);
    logic [PW-1:0] exp_pkt;
    int            exp_rsp;
    logic [7:0]    exp_chip, exp_data;
    bit            exp_tmo, glob, got_ld;
    int            rel, h;
    exp_rsp  = 0;
    exp_chip = 8'd0;
    exp_data = 8'd0;
    glob     = (chip == GID);
    exp_pkt  = model_packet(wr, chip, addr, wdata);
    check("ready_idle", 64'(cmd_ready), 64'd1);
    mon_clear();
    cmd_write = wr; cmd_chip_id = chip; cmd_addr = addr; cmd_wdata = wdata;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("ld_latency", 64'(ld_tx_data), 64'd1);
    got_ld = ld_tx_data;
    for (int i = 0; i < 4 && !got_ld; i++) begin
      tick();
      got_ld = ld_tx_data;
    end
    tx_busy = 1'b1;
    repeat ($urandom_range(1, 5)) tick();
    tx_busy = 1'b0;
    rel = cyc;
    if (!wr) begin
      repeat (late ? T : 1) tick();
      foreach (wq[i]) begin
        rx_data = wq[i];
        rx_data_flag = 1'b1;
        h = (hold > 0) ? hold : int'($urandom_range(1, 4));
        repeat (h) tick();
        rx_data_flag = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        if (model_match(wq[i], chip, addr)) begin
          exp_rsp++;
          exp_chip = wq[i][9:2];
          exp_data = wq[i][25:18];
          if (!glob) break;
        end
      end
    end
    exp_tmo = !wr && (exp_rsp == 0);
    for (int i = 0; i < 2 * T + 20 && mon_done == 0; i++) tick();
    repeat (3) tick();
    check("done_count", 64'(mon_done), 64'd1);
    check("ld_count", 64'(mon_ld), 64'd1);
    check("tx_packet", 64'(mon_tx), 64'(exp_pkt));
    check("rsp_count", 64'(mon_rsp), 64'(exp_rsp));
    check("rsp_timeout", 64'(mon_tmo), 64'(exp_tmo));
    if (exp_rsp > 0) begin
      check("rsp_chip_id", 64'(rsp_chip_id), 64'(exp_chip));
      check("rsp_data", 64'(rsp_data), 64'(exp_data));
    end
    if (exp_tmo) check("tmo_latency", 64'(done_cyc - rel), 64'(T + 1));
    check("idle_after", 64'({cmd_ready, busy}), 64'b10);
    wq.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin : main
    bit          wr;
    logic [7:0]  chip, addr, data;
    int          nw, kind, a;
    logic [PW-1:0] w;

    // Reset state
    repeat (3) tick();
    check("reset_outs", 64'({cmd_ready, ld_tx_data, rsp_valid, cmd_done, rsp_timeout, busy,
                             rsp_chip_id, rsp_data}), 64'({1'b1, 5'b0, 16'h0}));
    check("reset_tx_data", 64'(tx_data), 64'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Write chip 0x12 addr 0x05 data 0xA5
    do_cmd(1'b1, 8'h12, 8'h05, 8'hA5, 0, 1'b0);
    check("write_pkt_lit", 64'(mon_tx), 64'h0294_144A);

    // Unicast read with a matching reply
    wq.push_back(make_word(8'h12, 8'h05, 8'h3C));
    do_cmd(1'b0, 8'h12, 8'h05, 8'h00, 0, 1'b0);
    check("read_data_lit", 64'({rsp_chip_id, rsp_data}), 64'h123C);

    // Unicast read, only a reply from another chip
    wq.push_back(make_word(8'h13, 8'h05, 8'h77));
    do_cmd(1'b0, 8'h12, 8'h05, 8'h00, 0, 1'b0);

    // Broadcast read, three replies with the flag held 4 cycles each
    wq.push_back(make_word(8'h01, 8'h40, 8'h11));
    wq.push_back(make_word(8'h02, 8'h40, 8'h22));
    wq.push_back(make_word(8'h03, 8'h40, 8'h33));
    do_cmd(1'b0, GID, 8'h40, 8'h00, 4, 1'b0);
    check("global_rsp3", 64'(mon_rsp), 64'd3);

    // Match arriving in the timeout cycle
    wq.push_back(make_word(8'h33, 8'h07, 8'h5A));
    do_cmd(1'b0, 8'h33, 8'h07, 8'h00, 1, 1'b1);

    // tx UART stuck busy
    mon_clear();
    tx_busy = 1'b1;
    cmd_write = 1'b1; cmd_chip_id = 8'h21; cmd_addr = 8'h09; cmd_wdata = 8'h44;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    a = cyc;
    for (int i = 0; i < T + 10 && mon_done == 0; i++) tick();
    repeat (2) tick();
    check("stuck_ld", 64'(mon_ld), 64'd0);
    check("stuck_done", 64'(mon_done), 64'd1);
    check("stuck_tmo", 64'(mon_tmo), 64'd1);
    check("stuck_latency", 64'(done_cyc - a), 64'(T));
    tx_busy = 1'b0;
    repeat (2) tick();

    // Randomized commands
    for (int n = 0; n < 20; n++) begin
      wr   = 1'($urandom_range(0, 1));
      chip = ($urandom_range(0, 3) == 0) ? GID : 8'($urandom());
      addr = 8'($urandom());
      data = 8'($urandom());
      nw   = wr ? 0 : int'($urandom_range(0, 4));
      for (int k = 0; k < nw; k++) begin
        kind = int'($urandom_range(0, 4));
        w = make_word(($urandom_range(0, 1) == 1) ? chip : 8'($urandom()), addr, 8'($urandom()));
        case (kind)
          1: w[17:10] = addr ^ 8'h01;
          2: w[PW-1]  = 1'b0;
          3: w[1:0]   = 2'b10;
          4: w[9:2]   = chip ^ 8'h80;
          default: ;
        endcase
        wq.push_back(w);
      end
      do_cmd(wr, chip, addr, data, 0, 1'b0);
    end

    // Reset pulsed in REPLY with cmd_valid held high
    mon_clear();
    cmd_write = 1'b0; cmd_chip_id = 8'h12; cmd_addr = 8'h05; cmd_wdata = 8'h00;
    cmd_valid = 1'b1;
    tick();
    tick();
    tx_busy = 1'b1;
    repeat (2) tick();
    tx_busy = 1'b0;
    repeat (4) tick();
    check("busy_in_reply", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_outs", 64'({cmd_ready, ld_tx_data, rsp_valid, cmd_done, rsp_timeout, busy,
                              rsp_chip_id, rsp_data}), 64'({1'b1, 5'b0, 16'h0}));
    check("midrst_tx_data", 64'(tx_data), 64'd0);
    #1;
    reset_n = 1'b1;
    #1;
    check("postrst_ready", 64'({cmd_ready, busy}), 64'b10);
    cmd_valid = 1'b0;
    repeat (3) tick();
    check("postrst_no_done", 64'(mon_done), 64'd0);
    check("postrst_idle", 64'({cmd_ready, busy}), 64'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
